// File: rtl/cpu_test_sequencer_pkg.sv
// Shared constants for the CPU self-test sequencer: state encodings, default sizes, NOP word.
package cpu_test_sequencer_pkg;

  localparam int DEF_INSTR_MEM_SIZE = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int DEF_RUN_CYCLES     = 6;
  localparam int DEF_FAIL_WIDTH     = 8;

  localparam int NOP_WORD = 0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_FILL  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cpu_test_sequencer_if.sv
// Bus bundle between the sequencer (master) and CPU/memory/stimulus side (slave).
// Optional CPU_TEST_SEQUENCER_HALT_EN adds cpu_halt and timed_out.
interface cpu_test_sequencer_if #(
  parameter int INSTR_MEM_SIZE = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FAIL_WIDTH     = 8
);
  localparam int AW = $clog2(INSTR_MEM_SIZE);

  logic                      start;
  logic                      prog_valid;
  logic                      prog_last;
  logic [DATA_WIDTH-1:0]     prog_data;
  logic                      prog_ready;
  logic                      imem_we;
  logic [AW-1:0]             imem_addr;
  logic [DATA_WIDTH-1:0]     imem_wdata;
  logic                      cpu_reset;
  logic                      chk_valid;
  logic                      chk_last;
  logic [REG_ADDR_WIDTH-1:0] chk_reg;
  logic [DATA_WIDTH-1:0]     chk_value;
  logic                      chk_ready;
  logic [REG_ADDR_WIDTH-1:0] rf_raddr;
  logic [DATA_WIDTH-1:0]     rf_rdata;
  logic                      done;
  logic                      pass;
  logic [FAIL_WIDTH-1:0]     fail_count;
`ifdef CPU_TEST_SEQUENCER_HALT_EN
  logic                      cpu_halt;
  logic                      timed_out;

  modport master (
    input  start, prog_valid, prog_last, prog_data, chk_valid, chk_last, chk_reg, chk_value,
           rf_rdata, cpu_halt,
    output prog_ready, imem_we, imem_addr, imem_wdata, cpu_reset, chk_ready, rf_raddr,
           done, pass, fail_count, timed_out
  );
  modport slave (
    output start, prog_valid, prog_last, prog_data, chk_valid, chk_last, chk_reg, chk_value,
           rf_rdata, cpu_halt,
    input  prog_ready, imem_we, imem_addr, imem_wdata, cpu_reset, chk_ready, rf_raddr,
           done, pass, fail_count, timed_out
  );
`else
  modport master (
    input  start, prog_valid, prog_last, prog_data, chk_valid, chk_last, chk_reg, chk_value,
           rf_rdata,
    output prog_ready, imem_we, imem_addr, imem_wdata, cpu_reset, chk_ready, rf_raddr,
           done, pass, fail_count
  );
  modport slave (
    output start, prog_valid, prog_last, prog_data, chk_valid, chk_last, chk_reg, chk_value,
           rf_rdata,
    input  prog_ready, imem_we, imem_addr, imem_wdata, cpu_reset, chk_ready, rf_raddr,
           done, pass, fail_count
  );
`endif

endinterface

// File: rtl/cpu_test_sequencer_cycle_budget_counter.sv
// Loadable down-counter with zero flag; load wins over enable.
module cycle_budget_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cpu_test_sequencer.sv
// CPU self-test sequencer: load program, zero-fill, run for a cycle budget, check registers.
// Optional macro CPU_TEST_SEQUENCER_HALT_EN adds early RUN exit on cpu_halt and a timed_out flag.
module cpu_test_sequencer
  import cpu_test_sequencer_pkg::*;
#(
  parameter int INSTR_MEM_SIZE = DEF_INSTR_MEM_SIZE,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int RUN_CYCLES     = DEF_RUN_CYCLES,
  parameter int FAIL_WIDTH     = DEF_FAIL_WIDTH
) (
  input logic                  clock,
  input logic                  reset,
  cpu_test_sequencer_if.master bus
);

  localparam int AW = $clog2(INSTR_MEM_SIZE);
  localparam int CW = $clog2(max_int(INSTR_MEM_SIZE, RUN_CYCLES) + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(INSTR_MEM_SIZE - 1);
  localparam logic [CW-1:0] RUN_LOAD  = CW'(RUN_CYCLES - 1);
  localparam logic [FAIL_WIDTH-1:0] FAIL_MAX = '1;

  logic [2:0]            state;
  logic [AW-1:0]         addr;
  logic [FAIL_WIDTH-1:0] fail_count;
  logic                  cnt_load;
  logic                  cnt_enable;
  logic [CW-1:0]         cnt_value;
  logic                  cnt_zero;
  logic                  prog_hs;
  logic                  chk_hs;
  logic                  load_end;
  logic                  run_exit;
  logic                  halt;

`ifdef CPU_TEST_SEQUENCER_HALT_EN
  logic timed_out;
  assign halt          = bus.cpu_halt;
  assign bus.timed_out = (state == ST_DONE) && timed_out;
`else
  assign halt = 1'b0;
`endif

  assign prog_hs  = (state == ST_LOAD) && bus.prog_valid;
  assign chk_hs   = (state == ST_CHECK) && bus.chk_valid;
  assign load_end = prog_hs && (bus.prog_last || addr == LAST_ADDR);
  assign run_exit = (state == ST_RUN) && (cnt_zero || halt);

  // The counter times FILL as well as RUN: loaded with the number of fill writes
  // still to go after the current one, so its zero flag marks the last address.
  always_comb begin
    cnt_load   = 1'b0;
    cnt_enable = 1'b0;
    cnt_value  = '0;
    if (load_end) begin
      cnt_load  = 1'b1;
      cnt_value = (addr == LAST_ADDR) ? RUN_LOAD
                                      : CW'(INSTR_MEM_SIZE - 2 - int'(addr));
    end else if (state == ST_FILL) begin
      if (cnt_zero) begin
        cnt_load  = 1'b1;
        cnt_value = RUN_LOAD;
      end else begin
        cnt_enable = 1'b1;
      end
    end else if (state == ST_RUN) begin
      cnt_enable = 1'b1;
    end
  end

  cycle_budget_counter #(.WIDTH(CW)) u_budget (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .enable     (cnt_enable),
    .load_value (cnt_value),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      addr       <= '0;
      fail_count <= '0;
`ifdef CPU_TEST_SEQUENCER_HALT_EN
      timed_out  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state      <= ST_LOAD;
            addr       <= '0;
            fail_count <= '0;
`ifdef CPU_TEST_SEQUENCER_HALT_EN
            timed_out  <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (prog_hs) addr <= addr + AW'(1);
          if (load_end) state <= (addr == LAST_ADDR) ? ST_RUN : ST_FILL;
        end
        ST_FILL: begin
          addr <= addr + AW'(1);
          if (cnt_zero) state <= ST_RUN;
        end
        ST_RUN: begin
          if (run_exit) begin
            state <= ST_CHECK;
`ifdef CPU_TEST_SEQUENCER_HALT_EN
            timed_out <= !halt;
`endif
          end
        end
        ST_CHECK: begin
          if (chk_hs) begin
            if (bus.rf_rdata != bus.chk_value && fail_count != FAIL_MAX)
              fail_count <= fail_count + FAIL_WIDTH'(1);
            if (bus.chk_last) state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.prog_ready = (state == ST_LOAD);
  assign bus.imem_we    = prog_hs || (state == ST_FILL);
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = (state == ST_LOAD) ? bus.prog_data : DATA_WIDTH'(NOP_WORD);
  assign bus.cpu_reset  = (state != ST_RUN);
  assign bus.chk_ready  = (state == ST_CHECK);
  assign bus.rf_raddr   = (state == ST_CHECK) ? bus.chk_reg : '0;
  assign bus.done       = (state == ST_DONE);
  assign bus.pass       = (state == ST_DONE) && (fail_count == '0);
  assign bus.fail_count = fail_count;

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Directed bench for cpu_test_sequencer with a memory model and a register-file model.
module tb_cpu_test_sequencer;

  localparam int N  = 32;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int RC = 6;
  localparam int FW = 2;

  logic clock;
  logic reset;

  cpu_test_sequencer_if #(
    .INSTR_MEM_SIZE(N), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .FAIL_WIDTH(FW)
  ) bus ();

  cpu_test_sequencer #(
    .INSTR_MEM_SIZE(N), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .RUN_CYCLES(RC), .FAIL_WIDTH(FW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int low_cnt = 0;
  logic mem_clr;
  logic [DW-1:0] imem [N];
  logic [DW-1:0] rf [32];
  logic [RW-1:0] ent_reg [8];
  logic [DW-1:0] ent_val [8];

  assign bus.rf_rdata = rf[bus.rf_raddr];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!bus.cpu_reset) low_cnt <= low_cnt + 1;
    if (mem_clr) begin
      for (int a = 0; a < N; a++) imem[a] <= 32'hDEAD_BEEF;
    end else if (bus.imem_we) begin
      imem[bus.imem_addr] <= bus.imem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Starts a test, streams nwords, returns the LOAD entry cycle and run-edge baseline.
  task automatic load_prog(input int nwords, input bit use_last, input bit extra,
                           output int t0, output int base);
    int waits;
    mem_clr = 1'b1;
    step();
    mem_clr = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    t0 = cyc;
    check_eq("load_ready", bus.prog_ready, 1);
    for (int i = 0; i < nwords; i++) begin
      bus.prog_valid = 1'b1;
      bus.prog_data  = 32'hA500_0000 + i;
      bus.prog_last  = use_last && (i == nwords - 1);
      step();
    end
    bus.prog_last = 1'b0;
    if (extra) begin
      bus.prog_data = 32'hBAD0_0033;
      check_eq("word33_ready", bus.prog_ready, 0);
    end else begin
      bus.prog_valid = 1'b0;
    end
    waits = 0;
    while (bus.cpu_reset && waits < 200) begin
      step();
      waits++;
    end
    check_eq("run_entry_cycle", cyc - t0, N);
    base = low_cnt;
  endtask

  task automatic run_test(input int nwords, input bit use_last, input bit extra,
                          input int nent, input int exp_fail);
    int t0, base, waits;
    load_prog(nwords, use_last, extra, t0, base);
    waits = 0;
    while (!bus.cpu_reset && waits < 200) begin
      step();
      waits++;
    end
    bus.prog_valid = 1'b0;
    check_eq("run_len", low_cnt - base, RC);
    for (int e = 0; e < nent; e++) begin
      bus.chk_valid = 1'b1;
      bus.chk_reg   = ent_reg[e];
      bus.chk_value = ent_val[e];
      bus.chk_last  = (e == nent - 1);
      #1;
      if (e == 0) check_eq("rf_raddr", bus.rf_raddr, ent_reg[0]);
      check_eq("chk_ready", bus.chk_ready, 1);
      step();
    end
    bus.chk_valid = 1'b0;
    bus.chk_last  = 1'b0;
    check_eq("done", bus.done, 1);
    check_eq("pass", bus.pass, exp_fail == 0);
    check_eq("fail_count", bus.fail_count, exp_fail);
    check_eq("cpu_reset_done", bus.cpu_reset, 1);
`ifdef CPU_TEST_SEQUENCER_HALT_EN
    check_eq("timed_out", bus.timed_out, 1);
`endif
    for (int a = 0; a < N; a++)
      check_eq("imem_word", imem[a], (a < nwords) ? 32'hA500_0000 + a : 32'h0);
  endtask

  initial begin
    int t0, base;
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, base;
    reset = 1'b1;
    mem_clr = 1'b0;
    bus.start = 0; bus.prog_valid = 0; bus.prog_last = 0; bus.prog_data = '0;
    bus.chk_valid = 0; bus.chk_last = 0; bus.chk_reg = '0; bus.chk_value = '0;
`ifdef CPU_TEST_SEQUENCER_HALT_EN
    bus.cpu_halt = 1'b0;
`endif
    for (int r = 0; r < 32; r++) rf[r] = '0;
    rf[8] = 24; rf[9] = 5; rf[17] = 16; rf[18] = 0;
    ent_reg[0] = 8;  ent_val[0] = 24;
    ent_reg[1] = 9;  ent_val[1] = 5;
    ent_reg[2] = 17; ent_val[2] = 16;
    ent_reg[3] = 18; ent_val[3] = 0;
    repeat (3) step();
    reset = 1'b0;

    check_eq("rst_cpu_reset", bus.cpu_reset, 1);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_pass", bus.pass, 0);
    check_eq("rst_fail_count", bus.fail_count, 0);
    check_eq("rst_prog_ready", bus.prog_ready, 0);
    check_eq("rst_chk_ready", bus.chk_ready, 0);
    check_eq("rst_imem_we", bus.imem_we, 0);
    check_eq("rst_imem_addr", bus.imem_addr, 0);

    run_test(4, 1'b1, 1'b0, 4, 0);

    rf[9] = 4;
    run_test(4, 1'b1, 1'b0, 4, 1);
    rf[9] = 5;

    for (int e = 0; e < 5; e++) begin
      ent_reg[e] = RW'(e + 1);
      ent_val[e] = 7;
    end
    run_test(4, 1'b1, 1'b0, 5, 3);

    ent_reg[0] = 8;  ent_val[0] = 24;
    ent_reg[1] = 9;  ent_val[1] = 5;
    ent_reg[2] = 17; ent_val[2] = 16;
    ent_reg[3] = 18; ent_val[3] = 0;
    run_test(32, 1'b0, 1'b1, 4, 0);

    load_prog(4, 1'b1, 1'b0, t0, base);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("midrst_cpu_reset", bus.cpu_reset, 1);
    check_eq("midrst_done", bus.done, 0);
    check_eq("midrst_prog_ready", bus.prog_ready, 0);
    check_eq("midrst_chk_ready", bus.chk_ready, 0);
    check_eq("midrst_fail_count", bus.fail_count, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_eq("midrst_restart", bus.prog_ready, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;

`ifdef CPU_TEST_SEQUENCER_HALT_EN
    load_prog(4, 1'b1, 1'b0, t0, base);
    step();
    step();
    bus.cpu_halt = 1'b1;
    step();
    bus.cpu_halt = 1'b0;
    check_eq("halt_check_state", bus.chk_ready, 1);
    check_eq("halt_cpu_reset", bus.cpu_reset, 1);
    check_eq("halt_run_len", low_cnt - base, 3);
    bus.chk_valid = 1'b1; bus.chk_reg = 8; bus.chk_value = 24; bus.chk_last = 1'b1;
    step();
    bus.chk_valid = 1'b0; bus.chk_last = 1'b0;
    check_eq("halt_done", bus.done, 1);
    check_eq("halt_pass", bus.pass, 1);
    check_eq("halt_timed_out", bus.timed_out, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
